tone_detector: RTL and testbench

Receive-side companion to the countdown alarm: samples the alarm buzzer line, measures its period, and classifies it as silence, 1 kHz tone, 8 kHz tone, or invalid. It counts low/high tone alternations and drives the single 7-segment digit with the result. It sits on the board input side and is used to check the alarm output in loopback, or to watch another board's buzzer.

---
 rtl/tone_detector.sv | 168 ++++++++++++++++
 tb/tb_tone_detector.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/tone_detector.sv
// tone_detector: buzzer-line period classifier (none / 1 kHz / 8 kHz / invalid)
// with a low<->high alternation counter driving a single 7-segment digit.
// Optional feature macro: TONE_DET_SWCNT_EN (live switch_cnt, digit shows count).
module tone_detector #(
   parameter int unsigned CLK_HZ  = 50_000_000,
   parameter int unsigned P_LOW   = CLK_HZ / 1000,
   parameter int unsigned P_HIGH  = CLK_HZ / 8000,
   parameter int unsigned TOL     = 500,
   parameter int unsigned CONFIRM = 2,
   parameter int unsigned TIMEOUT = 100_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tone_in,
   output logic [1:0] tone_class,
   output logic       class_valid,
   output logic [3:0] switch_cnt,
   output logic [7:0] segment,
   output logic       digit
);

   localparam int unsigned MW = (CONFIRM < 2) ? 1 : $clog2(CONFIRM + 1);

   typedef enum logic [0:0] {IDLE, MEAS} state_t;
   typedef enum logic [1:0] {CLS_NONE = 2'd0, CLS_LOW = 2'd1, CLS_HIGH = 2'd2, CLS_INV = 2'd3} cls_t;

   logic          sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d, rise_q, rise_d;
   logic [16:0]   cnt_q, cnt_d;
   state_t        state_q, state_d;
   cls_t          cand_q, cand_d, class_q, class_d, cat;
   logic [MW-1:0] match_q, match_d;
   logic          valid_q, valid_d;
   logic          timeout_hit;
   logic [31:0]   period;

   function automatic logic [7:0] glyph(input logic [3:0] d);
      case (d)
         4'd0:    glyph = 8'b0011_1111;
         4'd1:    glyph = 8'b0000_0110;
         4'd2:    glyph = 8'b0101_1011;
         4'd3:    glyph = 8'b0100_1111;
         4'd4:    glyph = 8'b0110_0110;
         4'd5:    glyph = 8'b0110_1101;
         4'd6:    glyph = 8'b0111_1101;
         4'd7:    glyph = 8'b0000_0111;
         4'd8:    glyph = 8'b0111_1111;
         4'd9:    glyph = 8'b0110_1111;
         default: glyph = 8'b0111_1001;
      endcase
   endfunction

   // Synchronizer, edge detector, period counter, measurement FSM and classification
   always_comb begin
      sync1_d     = tone_in;
      sync2_d     = sync1_q;
      prev_d      = sync2_q;
      rise_d      = sync2_q & ~prev_q;
      cnt_d       = rise_q ? 17'd1 : ((cnt_q == '1) ? cnt_q : cnt_q + 17'd1);
      period      = 32'(cnt_q);
      state_d     = state_q;
      cand_d      = cand_q;
      match_d     = match_q;
      class_d     = class_q;
      timeout_hit = 1'b0;

      if (period >= P_LOW - TOL && period <= P_LOW + TOL)
         cat = CLS_LOW;
      else if (period >= P_HIGH - TOL && period <= P_HIGH + TOL)
         cat = CLS_HIGH;
      else
         cat = CLS_INV;

      // An edge takes priority over a timeout landing in the same cycle
      if (rise_q) begin
         if (state_q == IDLE) begin
            state_d = MEAS;
         end else begin
            if (cat == cand_q) begin
               if (match_q != MW'(CONFIRM))
                  match_d = match_q + MW'(1);
            end else begin
               cand_d  = cat;
               match_d = MW'(1);
            end
            if (match_d == MW'(CONFIRM) && cand_d != class_q)
               class_d = cand_d;
         end
      end else if (state_q == MEAS && period >= TIMEOUT) begin
         timeout_hit = 1'b1;
         state_d     = IDLE;
         class_d     = CLS_NONE;
         cand_d      = CLS_NONE;
         match_d     = '0;
      end

      valid_d = (class_d != class_q);
   end

   // State registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
         rise_q  <= 1'b0;
         cnt_q   <= '0;
         state_q <= IDLE;
         cand_q  <= CLS_NONE;
         match_q <= '0;
         class_q <= CLS_NONE;
         valid_q <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         prev_q  <= prev_d;
         rise_q  <= rise_d;
         cnt_q   <= cnt_d;
         state_q <= state_d;
         cand_q  <= cand_d;
         match_q <= match_d;
         class_q <= class_d;
         valid_q <= valid_d;
      end
   end

`ifdef TONE_DET_SWCNT_EN
   logic [3:0] sw_q, sw_d;

   // Alternation counter: counts direct low<->high class changes, saturates at 9
   always_comb begin
      sw_d = sw_q;
      if (timeout_hit)
         sw_d = '0;
      else if (((class_q == CLS_LOW && class_d == CLS_HIGH) ||
                (class_q == CLS_HIGH && class_d == CLS_LOW)) && sw_q != 4'd9)
         sw_d = sw_q + 4'd1;
   end

   // Alternation counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sw_q <= '0;
      else        sw_q <= sw_d;
   end

   assign switch_cnt = sw_q;
`else
   assign switch_cnt = '0;
`endif

   // Display decode from registered class (and count, when enabled)
   always_comb begin
      case (class_q)
         CLS_NONE: segment = glyph(4'd0);
         CLS_LOW:  segment = glyph(4'd1);
         CLS_HIGH: segment = glyph(4'd8);
         default:  segment = glyph(4'd14);
      endcase
`ifdef TONE_DET_SWCNT_EN
      if (class_q == CLS_LOW || class_q == CLS_HIGH)
         segment = glyph(sw_q);
`endif
   end

   assign tone_class  = class_q;
   assign class_valid = valid_q;
   assign digit       = 1'b1;

endmodule

// File: tb/tb_tone_detector.sv
// Directed bench for tone_detector with scaled-down periods.
module tb_tone_detector;

   localparam int P_LOW   = 400;
   localparam int P_HIGH  = 100;
   localparam int TOL     = 10;
   localparam int CONFIRM = 2;
   localparam int TIMEOUT = 1000;
`ifdef TONE_DET_SWCNT_EN
   localparam bit SW_EN = 1'b1;
`else
   localparam bit SW_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tone_in = 1'b0;
   logic [1:0] tone_class;
   logic       class_valid;
   logic [3:0] switch_cnt;
   logic [7:0] segment;
   logic       digit;

   int n_cmp = 0;
   int n_fail = 0;
   int vhigh = 0;

   tone_detector #(
      .CLK_HZ (400_000),
      .P_LOW  (P_LOW),
      .P_HIGH (P_HIGH),
      .TOL    (TOL),
      .CONFIRM(CONFIRM),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .tone_in    (tone_in),
      .tone_class (tone_class),
      .class_valid(class_valid),
      .switch_cnt (switch_cnt),
      .segment    (segment),
      .digit      (digit)
   );

   always #5 clk = ~clk;

   // counts cycles in which class_valid is high
   always @(negedge clk) if (class_valid) vhigh++;

   typedef struct {
      int         p;
      int         n;
      logic [1:0] cls;
      int         pulses;
   } vec_t;

   vec_t vecs[11];

   function automatic logic [7:0] glyph(input int d);
      case (d)
         0: return 8'h3F;  1: return 8'h06;  2: return 8'h5B;  3: return 8'h4F;
         4: return 8'h66;  5: return 8'h6D;  6: return 8'h7D;  7: return 8'h07;
         8: return 8'h7F;  9: return 8'h6F;  default: return 8'h79;
      endcase
   endfunction

   function automatic logic [7:0] exp_seg(input logic [1:0] c, input int sw);
      if (SW_EN && (c == 2'd1 || c == 2'd2)) return glyph(sw);
      case (c)
         2'd0: return glyph(0);
         2'd1: return glyph(1);
         2'd2: return glyph(8);
         default: return glyph(14);
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      tone_in = 1'b0;
      rst_n   = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   // one rising edge, then the rest of a period of p cycles
   task automatic pulse(input int p);
      tone_in = 1'b1;
      repeat (p / 2) @(negedge clk);
      tone_in = 1'b0;
      repeat (p - p / 2) @(negedge clk);
   endtask

   initial begin
      int base;
      int exp_sw;
      logic [1:0] exp_c;

      vecs[0]  = '{p: 400, n: 3, cls: 2'd1, pulses: 1};
      vecs[1]  = '{p: 400, n: 2, cls: 2'd0, pulses: 0};
      vecs[2]  = '{p: 110, n: 3, cls: 2'd2, pulses: 1};
      vecs[3]  = '{p: 111, n: 3, cls: 2'd3, pulses: 1};
      vecs[4]  = '{p:  90, n: 3, cls: 2'd2, pulses: 1};
      vecs[5]  = '{p:  89, n: 3, cls: 2'd3, pulses: 1};
      vecs[6]  = '{p: 390, n: 3, cls: 2'd1, pulses: 1};
      vecs[7]  = '{p: 410, n: 5, cls: 2'd1, pulses: 1};
      vecs[8]  = '{p: 411, n: 3, cls: 2'd3, pulses: 1};
      vecs[9]  = '{p: 389, n: 3, cls: 2'd3, pulses: 1};
      vecs[10] = '{p: 100, n: 5, cls: 2'd2, pulses: 1};

      // reset held with the line toggling
      rst_n = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tone_in = ~tone_in;
         @(negedge clk);
      end
      check("reset_class", 32'(tone_class), 0);
      check("reset_valid", 32'(class_valid), 0);
      check("reset_segment", 32'(segment), 32'h3F);
      check("reset_swcnt", 32'(switch_cnt), 0);
      check("reset_digit", 32'(digit), 1);

      // table-driven steady periods from reset
      for (int v = 0; v < 11; v++) begin
         do_reset();
         base = vhigh;
         repeat (vecs[v].n) pulse(vecs[v].p);
         check($sformatf("vec%0d_class", v), 32'(tone_class), 32'(vecs[v].cls));
         check($sformatf("vec%0d_pulses", v), vhigh - base, vecs[v].pulses);
         check($sformatf("vec%0d_segment", v), 32'(segment), 32'(exp_seg(vecs[v].cls, 0)));
      end

      // alternating 110/111: candidate flips every period, class never moves
      do_reset();
      base = vhigh;
      for (int i = 0; i < 8; i++) pulse((i % 2 == 0) ? P_HIGH + TOL : P_HIGH + TOL + 1);
      check("alt_bound_class", 32'(tone_class), 0);
      check("alt_bound_pulses", vhigh - base, 0);

      // exact latency at the third edge, then exact timeout cycle
      do_reset();
      pulse(P_LOW);
      pulse(P_LOW);
      base = vhigh;
      tone_in = 1'b1;
      for (int k = 1; k <= TIMEOUT + 6; k++) begin
         @(negedge clk);
         if (k == P_LOW / 2) tone_in = 1'b0;
         if (k == 3) check("lat_before", 32'(tone_class), 0);
         if (k == 4) begin
            check("lat_class", 32'(tone_class), 1);
            check("lat_valid", 32'(class_valid), 1);
         end
         if (k == 5) check("lat_valid_off", 32'(class_valid), 0);
         if (k == TIMEOUT + 3) check("to_before", 32'(tone_class), 1);
         if (k == TIMEOUT + 4) begin
            check("to_class", 32'(tone_class), 0);
            check("to_valid", 32'(class_valid), 1);
            check("to_swcnt", 32'(switch_cnt), 0);
         end
      end
      check("to_pulses", vhigh - base, 2);

      // edge landing in the timeout cycle: period of TIMEOUT is classed INVALID
      do_reset();
      base = vhigh;
      pulse(P_LOW);
      pulse(P_LOW);
      pulse(TIMEOUT);
      tone_in = 1'b1;
      repeat (6) @(negedge clk);
      check("coll_no_timeout", 32'(tone_class), 1);
      repeat (TIMEOUT / 2 - 6) @(negedge clk);
      tone_in = 1'b0;
      repeat (TIMEOUT - TIMEOUT / 2) @(negedge clk);
      tone_in = 1'b1;
      repeat (6) @(negedge clk);
      check("coll_class", 32'(tone_class), 3);
      check("coll_pulses", vhigh - base, 2);
      tone_in = 1'b0;

      // asynchronous reset mid-measurement clears outputs before the next edge
      do_reset();
      repeat (3) pulse(P_LOW);
      check("mid_pre_class", 32'(tone_class), 1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_class", 32'(tone_class), 0);
      check("mid_rst_segment", 32'(segment), 32'h3F);
      check("mid_rst_valid", 32'(class_valid), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // low/high bursts: alternation count and display
      do_reset();
      repeat (3) pulse(P_LOW);
      check("burst0_class", 32'(tone_class), 1);
      check("burst0_swcnt", 32'(switch_cnt), 0);
      for (int i = 1; i <= 10; i++) begin
         exp_c = (i % 2 == 1) ? 2'd2 : 2'd1;
         repeat (3) pulse((i % 2 == 1) ? P_HIGH : P_LOW);
         exp_sw = SW_EN ? ((i > 9) ? 9 : i) : 0;
         check($sformatf("burst%0d_class", i), 32'(tone_class), 32'(exp_c));
         check($sformatf("burst%0d_swcnt", i), 32'(switch_cnt), exp_sw);
         check($sformatf("burst%0d_segment", i), 32'(segment), 32'(exp_seg(exp_c, exp_sw)));
      end
      tone_in = 1'b0;
      repeat (TIMEOUT + 10) @(negedge clk);
      check("burst_to_class", 32'(tone_class), 0);
      check("burst_to_swcnt", 32'(switch_cnt), 0);
      check("burst_to_segment", 32'(segment), 32'h3F);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
